// File: rtl/demux1t2_8_stream.sv
// demux1t2_8_stream
// Registered 1-to-2 demultiplexer for an 8-bit valid/ready stream. Each
// accepted byte is steered to one of two output channels. Each channel owns a
// one-entry holding register, so the two consumers stall independently.
//
// Build option:
//   DEMUX1T2_8_RR_EN - when defined, the select input s is ignored and a
//                      1-bit round-robin pointer picks the target channel.
//                      The pointer toggles on every accept and never skips
//                      a busy channel.

module demux1t2_8_stream (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       s,
  output logic [7:0] o0,
  output logic       v0,
  input  logic       r0,
  output logic [7:0] o1,
  output logic       v1,
  input  logic       r1
);

  logic target;     // channel the offered byte goes to
  logic can_load0;  // slot 0 is empty or is draining this cycle
  logic can_load1;  // slot 1 is empty or is draining this cycle
  logic accept;     // handshake on the input side completes this cycle
  logic load0;
  logic load1;

`ifdef DEMUX1T2_8_RR_EN
  logic rr_ptr;
  logic unused_s;

  // s has no function in the round-robin build.
  assign unused_s = s;
  assign target   = rr_ptr;

  // Round-robin pointer: advances only on an accept, so a stalled target
  // channel blocks the input rather than being skipped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= 1'b0;
    end else if (accept) begin
      rr_ptr <= ~rr_ptr;
    end
  end
`else
  assign target = s;
`endif

  // A full slot whose consumer is taking the byte can be refilled in the same
  // cycle, which is what gives one byte per cycle without bubbles.
  assign can_load0 = !v0 || r0;
  assign can_load1 = !v1 || r1;

  // Ready never depends on in_valid. It is forced low while reset is
  // asserted, because the cleared slots would otherwise report empty.
  assign in_ready = rst_n && (target ? can_load1 : can_load0);
  assign accept   = in_valid && in_ready;
  assign load0    = accept && !target;
  assign load1    = accept &&  target;

  // Channel 0 holding register: load on accept, otherwise clear valid on drain.
  // NOTE: non-blocking assignments keep every register sampling pre-edge
  // values, so the load/drain decisions above see a consistent state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o0 <= 8'h00;
      v0 <= 1'b0;
    end else if (load0) begin
      o0 <= in_data;
      v0 <= 1'b1;
    end else if (r0) begin
      v0 <= 1'b0;
    end
  end

  // Channel 1 holding register: load on accept, otherwise clear valid on drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o1 <= 8'h00;
      v1 <= 1'b0;
    end else if (load1) begin
      o1 <= in_data;
      v1 <= 1'b1;
    end else if (r1) begin
      v1 <= 1'b0;
    end
  end

endmodule
